// File: rtl/core_bus_avalon.sv
// Core bus to Avalon-MM pipelined master bridge; one outstanding transaction, no bursts.
// Optional request timeout is enabled by defining CORE_BUS_TIMEOUT_EN.
module core_bus_avalon #(
  parameter int unsigned ADDR_W         = 30,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] bus_addr,
  input  logic              bus_start,
  input  logic              bus_write,
  input  logic [31:0]       bus_data_wr,
  input  logic [3:0]        bus_data_be,
  output logic              bus_ready,
  output logic [31:0]       bus_data_rd,
  output logic [31:0]       avl_address,
  output logic              avl_read,
  output logic              avl_write,
  output logic [31:0]       avl_writedata,
  output logic [3:0]        avl_byteenable,
  input  logic              avl_waitrequest,
  input  logic [31:0]       avl_readdata,
  input  logic              avl_readdatavalid,
  output logic              bus_timeout
);

  typedef enum logic [1:0] {StIdle, StReq, StRdWait, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [31:0]         wdata_q;
  logic [3:0]          be_q;
  logic                write_q, write_d;
  logic [31:0]         rdata_q, rdata_d;
  logic                ready_q, ready_d;
  logic                read_q, read_d;
  logic                wr_req_q, wr_req_d;
  logic                accept_start;

  assign accept_start = (state_q == StIdle) && bus_start;

`ifdef CORE_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1) + 1;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tmo_q, tmo_d;
`endif

  always_comb begin
    state_d = state_q;
    rdata_d = rdata_q;
    write_d = accept_start ? bus_write : write_q;
`ifdef CORE_BUS_TIMEOUT_EN
    tmo_d   = tmo_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (bus_start) state_d = StReq;
      end
      StReq: begin
        if (!avl_waitrequest) begin
          if (write_q) begin
            state_d = StDone;
          end else if (avl_readdatavalid) begin
            rdata_d = avl_readdata;
            state_d = StDone;
          end else begin
            state_d = StRdWait;
          end
        end
      end
      StRdWait: begin
        if (avl_readdatavalid) begin
          rdata_d = avl_readdata;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
`ifdef CORE_BUS_TIMEOUT_EN
    // A normal completion in the final cycle wins over the forced one.
    if ((state_q == StReq || state_q == StRdWait) && (state_d == state_q) &&
        (cnt_q == CntW'(TIMEOUT_CYCLES - 1))) begin
      state_d = StDone;
      rdata_d = 32'hDEAD_BEEF;
      tmo_d   = 1'b1;
    end
    if (state_d != state_q) begin
      cnt_d = '0;
    end else if (state_q == StReq || state_q == StRdWait) begin
      cnt_d = cnt_q + 1'b1;
    end else begin
      cnt_d = cnt_q;
    end
`endif
    // Request/ready flops are loaded from the next state so the outputs stay registered.
    read_d   = (state_d == StReq) && !write_d;
    wr_req_d = (state_d == StReq) && write_d;
    ready_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      addr_q   <= '0;
      wdata_q  <= '0;
      be_q     <= '0;
      write_q  <= 1'b0;
      rdata_q  <= '0;
      ready_q  <= 1'b0;
      read_q   <= 1'b0;
      wr_req_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      write_q  <= write_d;
      rdata_q  <= rdata_d;
      ready_q  <= ready_d;
      read_q   <= read_d;
      wr_req_q <= wr_req_d;
      if (accept_start) begin
        addr_q  <= bus_addr;
        wdata_q <= bus_data_wr;
        be_q    <= bus_data_be;
      end
    end
  end

`ifdef CORE_BUS_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
      tmo_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      tmo_q <= tmo_d;
    end
  end
  assign bus_timeout = tmo_q;
`else
  assign bus_timeout = 1'b0;
`endif

  assign bus_ready      = ready_q;
  assign bus_data_rd    = rdata_q;
  assign avl_address    = 32'({addr_q, 2'b00});
  assign avl_read       = read_q;
  assign avl_write      = wr_req_q;
  assign avl_writedata  = wdata_q;
  assign avl_byteenable = be_q;

`ifndef SYNTHESIS
  // A start in DONE is legal (dropped, core re-pulses); only REQ/RDWAIT count as busy.
  always @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus_start && (state_q == StReq || state_q == StRdWait)))
        else $warning("start while busy");
    end
  end
`endif

endmodule

// File: tb/tb_core_bus_avalon.sv
// Directed self-checking bench for core_bus_avalon; inputs change and outputs are sampled
// on the falling clock edge.
module tb_core_bus_avalon;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [29:0] bus_addr = '0;
  logic        bus_start = 1'b0;
  logic        bus_write = 1'b0;
  logic [31:0] bus_data_wr = '0;
  logic [3:0]  bus_data_be = '0;
  logic        bus_ready;
  logic [31:0] bus_data_rd;
  logic [31:0] avl_address;
  logic        avl_read;
  logic        avl_write;
  logic [31:0] avl_writedata;
  logic [3:0]  avl_byteenable;
  logic        avl_waitrequest = 1'b0;
  logic [31:0] avl_readdata = '0;
  logic        avl_readdatavalid = 1'b0;
  logic        bus_timeout;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  core_bus_avalon #(
    .ADDR_W        (30),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .bus_addr         (bus_addr),
    .bus_start        (bus_start),
    .bus_write        (bus_write),
    .bus_data_wr      (bus_data_wr),
    .bus_data_be      (bus_data_be),
    .bus_ready        (bus_ready),
    .bus_data_rd      (bus_data_rd),
    .avl_address      (avl_address),
    .avl_read         (avl_read),
    .avl_write        (avl_write),
    .avl_writedata    (avl_writedata),
    .avl_byteenable   (avl_byteenable),
    .avl_waitrequest  (avl_waitrequest),
    .avl_readdata     (avl_readdata),
    .avl_readdatavalid(avl_readdatavalid),
    .bus_timeout      (bus_timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic start_txn(input logic we, input logic [29:0] a, input logic [31:0] d,
                           input logic [3:0] be);
    bus_start   = 1'b1;
    bus_write   = we;
    bus_addr    = a;
    bus_data_wr = d;
    bus_data_be = be;
  endtask

  int rd_cnt, rdy_cnt, rdy_cyc;
  logic [31:0] rdy_data;
  logic bad;

  initial begin
    #1;
    check_eq("rst_ready", 32'(bus_ready), 32'd0);
    check_eq("rst_rdata", bus_data_rd, 32'd0);
    check_eq("rst_addr", avl_address, 32'd0);
    check_eq("rst_rw", 32'({avl_read, avl_write}), 32'd0);
    check_eq("rst_wdata_be", 32'({avl_writedata, avl_byteenable}), 32'd0);
    check_eq("rst_timeout", 32'(bus_timeout), 32'd0);
    step();
    rst_n = 1'b1;
    step();

    // Write, no stall
    start_txn(1'b1, 30'h10, 32'hCAFE_F00D, 4'b0011);
    step();
    bus_start = 1'b0;
    check_eq("wr_req", 32'({avl_read, avl_write}), 32'd1);
    check_eq("wr_addr", avl_address, 32'h40);
    check_eq("wr_data", avl_writedata, 32'hCAFE_F00D);
    check_eq("wr_be", 32'(avl_byteenable), 32'h3);
    check_eq("wr_noready", 32'(bus_ready), 32'd0);
    step();
    check_eq("wr_ready", 32'(bus_ready), 32'd1);
    check_eq("wr_req_drop", 32'({avl_read, avl_write}), 32'd0);
    check_eq("wr_rdata_kept", bus_data_rd, 32'd0);
    step();
    check_eq("wr_ready_pulse", 32'(bus_ready), 32'd0);

    // Read, waitrequest high 3 cycles, readdatavalid 2 cycles after accept
    avl_readdata = 32'hFFFF_FFFF;
    start_txn(1'b0, 30'h20, 32'h0, 4'hF);
    rd_cnt = 0; rdy_cnt = 0; rdy_cyc = 0; rdy_data = '0;
    for (int i = 1; i <= 10; i++) begin
      step();
      bus_start = 1'b0;
      if (i == 1) check_eq("rd_addr", avl_address, 32'h80);
      if (avl_read) rd_cnt++;
      if (bus_ready) begin
        rdy_cnt++;
        rdy_cyc  = i;
        rdy_data = bus_data_rd;
      end
      avl_waitrequest   = (i < 4);
      avl_readdatavalid = (i == 6);
      avl_readdata      = (i == 6) ? 32'h1234_5678 : 32'hFFFF_FFFF;
    end
    check_eq("rd_held_cycles", 32'(rd_cnt), 32'd4);
    check_eq("rd_ready_count", 32'(rdy_cnt), 32'd1);
    check_eq("rd_ready_cycle", 32'(rdy_cyc), 32'd7);
    check_eq("rd_data", rdy_data, 32'h1234_5678);
    check_eq("rd_data_hold", bus_data_rd, 32'h1234_5678);

    // Read with readdatavalid in the accept cycle; start during DONE is dropped
    start_txn(1'b0, 30'h5, 32'h0, 4'hF);
    step();
    bus_start = 1'b0;
    check_eq("fast_req", 32'({avl_read, avl_write}), 32'd2);
    check_eq("fast_addr", avl_address, 32'h14);
    avl_readdatavalid = 1'b1;
    avl_readdata      = 32'hA5A5_0F0F;
    step();
    avl_readdatavalid = 1'b0;
    check_eq("fast_ready", 32'(bus_ready), 32'd1);
    check_eq("fast_data", bus_data_rd, 32'hA5A5_0F0F);
    check_eq("fast_req_drop", 32'({avl_read, avl_write}), 32'd0);
    start_txn(1'b1, 30'h9, 32'h1, 4'h1);
    step();
    bus_start = 1'b0;
    check_eq("done_start_ignored", 32'({avl_read, avl_write, bus_ready}), 32'd0);

    // Write completion keeps previous read data
    start_txn(1'b1, 30'h9, 32'h0000_0001, 4'b1000);
    step();
    bus_start = 1'b0;
    check_eq("wr2_be", 32'(avl_byteenable), 32'h8);
    step();
    check_eq("wr2_ready", 32'(bus_ready), 32'd1);
    check_eq("wr2_rdata_kept", bus_data_rd, 32'hA5A5_0F0F);
    step();

    // bus_start during RDWAIT is ignored
    start_txn(1'b0, 30'h7, 32'h0, 4'hF);
    step();
    bus_start = 1'b0;
    check_eq("busy_req", 32'(avl_read), 32'd1);
    step();
    check_eq("busy_rdwait", 32'({avl_read, avl_write}), 32'd0);
    start_txn(1'b1, 30'h3, 32'hBBBB_BBBB, 4'hF);
    step();
    bus_start = 1'b0;
    check_eq("busy_no_second_req", 32'({avl_read, avl_write, bus_ready}), 32'd0);
    avl_readdatavalid = 1'b1;
    avl_readdata      = 32'h55AA_55AA;
    step();
    avl_readdatavalid = 1'b0;
    check_eq("busy_ready", 32'(bus_ready), 32'd1);
    check_eq("busy_data", bus_data_rd, 32'h55AA_55AA);
    step();
    check_eq("busy_single_ready", 32'({avl_read, avl_write, bus_ready}), 32'd0);

    // Async reset while avl_write is asserted in REQ
    avl_waitrequest = 1'b1;
    start_txn(1'b1, 30'h11, 32'h1111_1111, 4'hF);
    step();
    bus_start = 1'b0;
    check_eq("rstmid_req", 32'(avl_write), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("rstmid_write_drop", 32'(avl_write), 32'd0);
    check_eq("rstmid_rdata_clr", bus_data_rd, 32'd0);
    check_eq("rstmid_addr_clr", avl_address, 32'd0);
    step();
    rst_n = 1'b1;
    avl_waitrequest = 1'b0;
    bad = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (bus_ready || avl_write || avl_read) bad = 1'b1;
    end
    check_eq("rstmid_no_ready", 32'(bad), 32'd0);

    // Normal write after reset, top of address space
    start_txn(1'b1, 30'h3FFF_FFFF, 32'h8765_4321, 4'hF);
    step();
    bus_start = 1'b0;
    check_eq("post_rst_addr", avl_address, 32'hFFFF_FFFC);
    check_eq("post_rst_wr", 32'(avl_write), 32'd1);
    step();
    check_eq("post_rst_ready", 32'(bus_ready), 32'd1);
    step();

    // Stuck waitrequest
    avl_waitrequest = 1'b1;
    start_txn(1'b0, 30'h44, 32'h0, 4'hF);
    rd_cnt = 0; rdy_cnt = 0; rdy_cyc = 0; rdy_data = '0;
`ifdef CORE_BUS_TIMEOUT_EN
    for (int i = 1; i <= 12; i++) begin
      step();
      bus_start = 1'b0;
      if (avl_read) rd_cnt++;
      if (bus_ready) begin
        rdy_cnt++;
        rdy_cyc  = i;
        rdy_data = bus_data_rd;
      end
    end
    check_eq("tmo_read_cycles", 32'(rd_cnt), 32'd8);
    check_eq("tmo_ready_count", 32'(rdy_cnt), 32'd1);
    check_eq("tmo_ready_cycle", 32'(rdy_cyc), 32'd9);
    check_eq("tmo_data", rdy_data, 32'hDEAD_BEEF);
    check_eq("tmo_flag", 32'(bus_timeout), 32'd1);
    avl_waitrequest = 1'b0;
    start_txn(1'b1, 30'h1, 32'h2, 4'hF);
    step();
    bus_start = 1'b0;
    step();
    check_eq("tmo_flag_sticky", 32'({bus_ready, bus_timeout}), 32'd3);
`else
    for (int i = 1; i <= 20; i++) begin
      step();
      bus_start = 1'b0;
      if (avl_read) rd_cnt++;
      if (bus_ready) rdy_cnt++;
    end
    check_eq("stall_read_held", 32'(rd_cnt), 32'd20);
    check_eq("stall_no_ready", 32'(rdy_cnt), 32'd0);
    check_eq("stall_no_timeout", 32'(bus_timeout), 32'd0);
    avl_waitrequest   = 1'b0;
    avl_readdatavalid = 1'b1;
    avl_readdata      = 32'h0BAD_F00D;
    step();
    avl_readdatavalid = 1'b0;
    check_eq("stall_release_ready", 32'(bus_ready), 32'd1);
    check_eq("stall_release_data", bus_data_rd, 32'h0BAD_F00D);
`endif
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
